// File: rtl/cpu_hazard_pkg.sv
// cpu_hazard_pkg: shared constants, shadow-entry type and match helper for hazard_ctrl
package cpu_hazard_pkg;
    localparam int DEF_REG_ADDR_W = 5;
    localparam logic [1:0] FWD_REGFILE = 2'd0;
    localparam logic [1:0] FWD_EXME = 2'd1;
    localparam logic [1:0] FWD_MEWB = 2'd2;
    typedef struct packed {
        logic valid;
        logic reg_write;
        logic [DEF_REG_ADDR_W-1:0] waddr;
        logic mem_read;
        logic [DEF_REG_ADDR_W-1:0] rs;
        logic [DEF_REG_ADDR_W-1:0] rt;
        logic uses_rs;
        logic uses_rt;
    } hz_entry_t;
    // r0 is hardwired zero, so it never creates a dependence
    function automatic logic reg_match(hz_entry_t e, logic [DEF_REG_ADDR_W-1:0] r);
        return e.valid && e.reg_write && (e.waddr == r) && (r != '0);
    endfunction
endpackage

// File: rtl/hazard_track_reg.sv
// hazard_track_reg: one shadow pipeline entry
//   clk, arst_n (sync, active-low), enable (advance), clear (load invalid), d (next entry), q (entry)
module hazard_track_reg
    import cpu_hazard_pkg::*;
(
    input  logic      clk,
    input  logic      arst_n,
    input  logic      enable,
    input  logic      clear,
    input  hz_entry_t d,
    output hz_entry_t q
);
    hz_entry_t entry_d, entry_q;
    always_comb entry_d = clear ? '0 : d;
    always_ff @(posedge clk) begin
        if (!arst_n) entry_q <= '0;
        else if (enable) entry_q <= entry_d;
    end
    assign q = entry_q;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/bubble and EX forwarding control for the pipelined CPU
//   in : clk, arst_n (sync, active-low), enable, id_* (ID instruction), redirect
//   out: stall, flush_if_id, bubble_id_ex, fwd_sel_a/b, stage_valid, stall_cycles
//   FORWARDING_EN: when defined, EX/ME and ME/WB results are forwarded instead of stalling
module hazard_ctrl
    import cpu_hazard_pkg::*;
#(
    parameter int REG_ADDR_W   = DEF_REG_ADDR_W,
    parameter int N_STAGES     = 3,
    parameter int BRANCH_STAGE = 2
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  enable,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic                  id_reg_write,
    input  logic [REG_ADDR_W-1:0] id_waddr,
    input  logic                  id_mem_read,
    input  logic                  redirect,
    output logic                  stall,
    output logic                  flush_if_id,
    output logic                  bubble_id_ex,
    output logic [1:0]            fwd_sel_a,
    output logic [1:0]            fwd_sel_b,
    output logic [N_STAGES-1:0]   stage_valid,
    output logic [31:0]           stall_cycles
);
    hz_entry_t entries [N_STAGES];
    hz_entry_t id_entry;
    logic hazard;
    logic unused_fields;
    logic [31:0] stall_cycles_d, stall_cycles_q;

    always_comb begin
        id_entry = '{valid: id_valid, reg_write: id_reg_write, waddr: id_waddr,
                     mem_read: id_mem_read, rs: id_rs, rt: id_rt,
                     uses_rs: id_uses_rs, uses_rt: id_uses_rt};
        hazard = 1'b0;
        unused_fields = 1'b0;
        for (int k = 0; k < N_STAGES; k++) begin
`ifdef FORWARDING_EN
            // ME and WB results reach EX through the forwarding muxes; only a load in EX must wait
            if ((k == 0) ? entries[k].mem_read : (k >= 3))
`endif
                hazard = hazard | (id_uses_rs && reg_match(entries[k], id_rs))
                                | (id_uses_rt && reg_match(entries[k], id_rt));
            unused_fields = unused_fields ^ (^entries[k]);
        end
        hazard = hazard && id_valid;
        flush_if_id = redirect && enable;
        stall = hazard && !redirect && enable;
        bubble_id_ex = stall || flush_if_id;
`ifdef FORWARDING_EN
        fwd_sel_a = !(entries[0].valid && entries[0].uses_rs) ? FWD_REGFILE :
                    reg_match(entries[1], entries[0].rs) ? FWD_EXME :
                    reg_match(entries[2], entries[0].rs) ? FWD_MEWB : FWD_REGFILE;
        fwd_sel_b = !(entries[0].valid && entries[0].uses_rt) ? FWD_REGFILE :
                    reg_match(entries[1], entries[0].rt) ? FWD_EXME :
                    reg_match(entries[2], entries[0].rt) ? FWD_MEWB : FWD_REGFILE;
`else
        fwd_sel_a = FWD_REGFILE;
        fwd_sel_b = FWD_REGFILE;
`endif
        stall_cycles_d = (stall && stall_cycles_q != '1) ? stall_cycles_q + 32'd1 : stall_cycles_q;
    end

    for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
        if (k == 0) begin : g_ex
            hazard_track_reg u_reg (
                .clk(clk), .arst_n(arst_n), .enable(enable),
                .clear(bubble_id_ex), .d(id_entry), .q(entries[k])
            );
        end else begin : g_later
            // wrong-path instructions behind a resolving branch are squashed as they advance
            hazard_track_reg u_reg (
                .clk(clk), .arst_n(arst_n), .enable(enable),
                .clear((k < BRANCH_STAGE) && flush_if_id), .d(entries[k-1]), .q(entries[k])
            );
        end
        assign stage_valid[k] = entries[k].valid;
    end

    always_ff @(posedge clk) begin
        if (!arst_n) stall_cycles_q <= '0;
        else stall_cycles_q <= stall_cycles_d;
    end
    assign stall_cycles = stall_cycles_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: randomized and directed checks of hazard_ctrl against an in-flight instruction queue model
module tb_hazard_ctrl;
    localparam int W = 5;
    localparam int N = 3;
    localparam int B = 2;
`ifdef FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic arst_n, enable, id_valid, id_uses_rs, id_uses_rt, id_reg_write, id_mem_read, redirect;
    logic [W-1:0] id_rs, id_rt, id_waddr;
    logic stall, flush_if_id, bubble_id_ex;
    logic [1:0] fwd_sel_a, fwd_sel_b;
    logic [N-1:0] stage_valid;
    logic [31:0] stall_cycles;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        bit v, rw, mr, ur, ut;
        logic [W-1:0] wa, rs, rt;
    } ins_t;

    ins_t pipe [$];
    ins_t nop;
    logic [31:0] m_cnt;
    logic obs_stall, obs_flush, obs_bub;
    logic [1:0] obs_fa, obs_fb;
    logic [N-1:0] obs_sv;
    logic [31:0] obs_cnt;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_ADDR_W(W), .N_STAGES(N), .BRANCH_STAGE(B)) dut (
        .clk(clk), .arst_n(arst_n), .enable(enable), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_reg_write(id_reg_write), .id_waddr(id_waddr), .id_mem_read(id_mem_read),
        .redirect(redirect), .stall(stall), .flush_if_id(flush_if_id),
        .bubble_id_ex(bubble_id_ex), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
        .stage_valid(stage_valid), .stall_cycles(stall_cycles)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic ins_t mk(bit rw, bit mr, int wa, bit ur, int rs, bit ut, int rt);
        ins_t i;
        i.v = 1'b1; i.rw = rw; i.mr = mr; i.ur = ur; i.ut = ut;
        i.wa = W'(wa); i.rs = W'(rs); i.rt = W'(rt);
        return i;
    endfunction

    function automatic ins_t rnd();
        ins_t i;
        i.v = ($urandom % 4) != 0;
        i.rw = $urandom % 2;
        i.mr = i.rw && (($urandom % 3) == 0);
        i.ur = $urandom % 2;
        i.ut = $urandom % 2;
        i.wa = W'($urandom % 4);
        i.rs = W'($urandom % 4);
        i.rt = W'($urandom % 4);
        return i;
    endfunction

    function automatic bit writes(ins_t e, logic [W-1:0] r);
        return e.v && e.rw && (e.wa == r) && (r != '0);
    endfunction

    function automatic logic [1:0] fwd_src(logic [W-1:0] r);
        return writes(pipe[1], r) ? 2'd1 : writes(pipe[2], r) ? 2'd2 : 2'd0;
    endfunction

    task automatic model_clear();
        pipe.delete();
        for (int k = 0; k < N; k++) pipe.push_back(nop);
        m_cnt = '0;
    endtask

    task automatic cycle(input bit rst_n, input bit en, input ins_t id, input bit redir, input bit chk);
        bit haz, es, ef, eb;
        logic [1:0] efa, efb;
        logic [N-1:0] esv;
        @(negedge clk);
        arst_n = rst_n; enable = en; redirect = redir;
        id_valid = id.v; id_reg_write = id.rw; id_mem_read = id.mr;
        id_uses_rs = id.ur; id_uses_rt = id.ut;
        id_waddr = id.wa; id_rs = id.rs; id_rt = id.rt;
        #1;
        haz = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (FWD ? ((k == 0) ? pipe[k].mr : (k >= 3)) : 1'b1)
                haz |= (id.ur && writes(pipe[k], id.rs)) || (id.ut && writes(pipe[k], id.rt));
            esv[k] = pipe[k].v;
        end
        haz &= id.v;
        es = haz && !redir && en;
        ef = redir && en;
        eb = es || ef;
        efa = (FWD && pipe[0].v && pipe[0].ur) ? fwd_src(pipe[0].rs) : 2'd0;
        efb = (FWD && pipe[0].v && pipe[0].ut) ? fwd_src(pipe[0].rt) : 2'd0;
        if (chk) begin
            check("stall", stall, es);
            check("flush", flush_if_id, ef);
            check("bubble", bubble_id_ex, eb);
            check("fwd_a", fwd_sel_a, efa);
            check("fwd_b", fwd_sel_b, efb);
            check("stage_valid", stage_valid, esv);
            check("stall_cycles", stall_cycles, m_cnt);
        end
        obs_stall = stall; obs_flush = flush_if_id; obs_bub = bubble_id_ex;
        obs_fa = fwd_sel_a; obs_fb = fwd_sel_b; obs_sv = stage_valid; obs_cnt = stall_cycles;
        @(posedge clk);
        if (!rst_n) model_clear();
        else if (en) begin
            pipe.push_front(eb ? nop : id);
            void'(pipe.pop_back());
            if (ef) for (int k = 0; k < B; k++) pipe[k].v = 1'b0;
            if (es && m_cnt != '1) m_cnt++;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < N + 1; i++) cycle(1'b1, 1'b1, nop, 1'b0, 1'b1);
    endtask

    task automatic issue(input ins_t id, output int stalls);
        bit done = 1'b0;
        stalls = 0;
        for (int i = 0; i < 16 && !done; i++) begin
            cycle(1'b1, 1'b1, id, 1'b0, 1'b1);
            if (obs_stall) stalls++;
            else done = 1'b1;
        end
        if (!done) check("issue_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int s;
        logic [31:0] c0;
        nop = '{default: '0};
        arst_n = 1'b0; enable = 1'b1; redirect = 1'b0; id_valid = 1'b0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_reg_write = 1'b0; id_mem_read = 1'b0;
        id_rs = '0; id_rt = '0; id_waddr = '0;
        model_clear();

        cycle(1'b0, 1'b1, mk(1, 0, 3, 1, 1, 1, 2), 1'b1, 1'b0);
        cycle(1'b0, 1'b1, mk(1, 0, 3, 1, 1, 1, 2), 1'b1, 1'b0);
        cycle(1'b1, 1'b1, nop, 1'b0, 1'b1);
        check("rst_stage_valid", obs_sv, 0);
        check("rst_stall_cycles", obs_cnt, 0);
        check("rst_fwd_a", obs_fa, 0);
        check("rst_fwd_b", obs_fb, 0);
        check("rst_stall", obs_stall, 0);

        drain();
        c0 = obs_cnt;
        issue(mk(1, 0, 3, 1, 1, 1, 2), s);
        issue(mk(1, 0, 4, 1, 3, 1, 5), s);
        check("raw_stalls", s, FWD ? 0 : 3);
        cycle(1'b1, 1'b1, nop, 1'b0, 1'b1);
        check("raw_fwd_a", obs_fa, FWD ? 1 : 0);
        drain();
        check("raw_cnt", obs_cnt - c0, FWD ? 0 : 3);

        c0 = obs_cnt;
        issue(mk(1, 0, 3, 1, 1, 1, 2), s);
        issue(nop, s);
        issue(mk(1, 0, 4, 1, 3, 1, 5), s);
        check("gap_stalls", s, FWD ? 0 : 2);
        cycle(1'b1, 1'b1, nop, 1'b0, 1'b1);
        check("gap_fwd_a", obs_fa, FWD ? 2 : 0);
        drain();

        c0 = obs_cnt;
        issue(mk(1, 1, 3, 1, 1, 0, 0), s);
        issue(mk(1, 0, 4, 1, 3, 1, 3), s);
        check("load_use_stalls", s, FWD ? 1 : 3);
        cycle(1'b1, 1'b1, nop, 1'b0, 1'b1);
        check("load_use_fwd_a", obs_fa, FWD ? 2 : 0);
        check("load_use_fwd_b", obs_fb, FWD ? 2 : 0);
        drain();
        check("load_use_cnt", obs_cnt - c0, FWD ? 1 : 3);

        issue(mk(1, 0, 0, 1, 1, 1, 2), s);
        issue(mk(1, 0, 4, 1, 0, 1, 0), s);
        check("r0_stalls", s, 0);
        cycle(1'b1, 1'b1, nop, 1'b0, 1'b1);
        check("r0_fwd_a", obs_fa, 0);
        check("r0_fwd_b", obs_fb, 0);
        drain();

        issue(mk(1, 0, 3, 1, 1, 1, 2), s);
        cycle(1'b1, 1'b1, mk(1, 0, 4, 1, 3, 1, 5), 1'b1, 1'b1);
        check("redir_stall", obs_stall, 0);
        check("redir_flush", obs_flush, 1);
        check("redir_bubble", obs_bub, 1);
        cycle(1'b1, 1'b1, nop, 1'b0, 1'b1);
        check("redir_sv_low", obs_sv[1:0], 0);
        drain();

        issue(mk(1, 0, 3, 1, 1, 1, 2), s);
        cycle(1'b1, 1'b0, mk(1, 0, 4, 1, 3, 1, 3), 1'b0, 1'b1);
        check("dis_stall", obs_stall, 0);
        check("dis_bubble", obs_bub, 0);
        drain();

        for (int i = 0; i < 400; i++)
            cycle(($urandom % 64) != 0, ($urandom % 8) != 0, rnd(), ($urandom % 8) == 0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Hazard controller for the 5-stage pipelined CPU.
- Keeps a shadow shift register of in-flight instructions from EX to WB and compares their destination registers with the operands of the instruction in ID.
- Outputs: pipeline stall, IF/ID flush, ID/EX bubble, and EX operand-forwarding selects.
- Depth is parametrised, so pipelines with extra memory/writeback stages reuse the block; the branch/jump resolve stage is also configurable.

Parameters:
- REG_ADDR_W, 5: register address width.
- N_STAGES, 3: tracked stages after ID. Entry 0 = EX, entry 1 = ME, entry N_STAGES-1 = WB. Legal range 3..6.
- BRANCH_STAGE, 2: entry index where branch/jump redirect resolves (1 = EX, 2 = ME). Must be < N_STAGES.

Ports:
- clk  in  1  system clock
- arst_n  in  1  reset
- enable  in  1  pipeline advance enable; state holds when low
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  REG_ADDR_W  ID source registers
- id_uses_rs, id_uses_rt  in  1  ID instruction reads rs / rt
- id_reg_write  in  1  ID instruction writes the register file
- id_waddr  in  REG_ADDR_W  ID destination register
- id_mem_read  in  1  ID instruction is a load
- redirect  in  1  taken branch or jump, resolved in BRANCH_STAGE
- stall  out  1  hold PC and IF/ID
- flush_if_id  out  1  squash the IF/ID register
- bubble_id_ex  out  1  load a NOP into ID/EX
- fwd_sel_a, fwd_sel_b  out  2  EX operand source: 0 = ID/EX regfile data, 1 = EX/ME alu_out, 2 = ME/WB write data
- stage_valid  out  N_STAGES  per-entry valid bits
- stall_cycles  out  32  performance counter

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-low.
- Reset: at a clk edge with arst_n=0, all entries go invalid and stall_cycles goes to 0. After reset: stall=0, flush_if_id=0, bubble_id_ex=0, fwd_sel_*=0, stage_valid=0.
- Entry fields: valid, reg_write, waddr, mem_read, rs, rt, uses_rs, uses_rt.
- Register 0 never matches in any hazard or forwarding compare.
- Match(k, r): entry k is valid, has reg_write=1, waddr==r, and r!=0.
- Hazard: the ID instruction is valid, and uses_rs with Match(k, id_rs) or uses_rt with Match(k, id_rt), for the entries k defined under Optional Feature.
- stall = hazard & ~redirect & enable. bubble_id_ex = stall | (redirect & enable). flush_if_id = redirect & enable.
- Advance on each clk edge with enable=1 and arst_n=1:
  - entry[k] <= entry[k-1] for k >= 1.
  - entry[0] <= ID fields if ~bubble_id_ex, else an invalid entry.
  - On redirect, entries with index < BRANCH_STAGE also go invalid. These are the wrong-path instructions behind the branch.
  - Redirect has priority over stall.
- Latency: every output is combinational from the current entries and ID inputs. Shadow state moves one stage per enabled cycle.
- Forwarding selects use EX entry 0 rs/rt against entries 1 and 2. The nearest match wins (1 over 2). A select is 0 if entry 0 is invalid or does not use that operand.
- stall_cycles increments on every cycle with stall=1 and saturates at 0xFFFFFFFF.
- enable=0: shadow state and counter hold; outputs still evaluate but stall, flush and bubble are forced to 0.
- Reset asserted mid-stall or mid-redirect clears everything at that edge. No pending redirect survives reset.

Optional Feature:
- Macro: FORWARDING_EN.
- Defined:
  - Hazard checks only entry 0 with mem_read=1 (load-use, one bubble), plus entries 3..N_STAGES-1.
  - Entries 1 and 2 are covered by fwd_sel_* driven as specified.
- Undefined:
  - Hazard checks all entries 0..N_STAGES-1.
  - fwd_sel_a and fwd_sel_b are tied to 0.

Decomposition:
- Package cpu_hazard_pkg holds: FWD_REGFILE=0, FWD_EXME=1, FWD_MEWB=2; the entry struct typedef; the default REG_ADDR_W.
- Sub-module hazard_track_reg: one entry register with sync active-low reset, enable, and clear. Instantiate N_STAGES times.

Test Plan:
- Reset: hold arst_n=0 for 2 edges with redirect=1 and id_valid=1, then release → stage_valid=0, stall_cycles=0, no fwd_sel.
- With FORWARDING_EN:
  - add r3,r1,r2 then sub r4,r3,r5 → stall=0; in sub's EX cycle fwd_sel_a=1.
  - One instruction gap between them → fwd_sel_a=2.
- With FORWARDING_EN: lw r3 then add r4,r3,r3 → exactly 1 stall cycle; add then sees fwd_sel_a=fwd_sel_b=2; stall_cycles=1.
- Without FORWARDING_EN: add r3 then dependent sub on r3 → stall for 3 cycles (N_STAGES=3); fwd_sel=0; stall_cycles=3.
- BRANCH_STAGE=2: redirect=1 while ID shows a hazard → stall=0, flush_if_id=1, bubble_id_ex=1; next cycle stage_valid[1:0]=00.
- Dependence on r0: add r0 then use r0 → no stall, fwd_sel=0.
